// File: rtl/fetch_pipe_ctrl_pkg.sv
// rtl/fetch_pipe_ctrl_pkg.sv - shared FSM encodings, NOP word and PC helper for the fetch stage
package fetch_pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HOLD   = 2'd2,
        ST_SQUASH = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP           = 32'd4;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - generic pipeline register with hold/load/flush and a valid bit
module if_id_reg #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         flush_i,
    input  logic [W-1:0] flush_data_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         valid_o
);

    logic [W-1:0] data_q;
    logic         valid_q;

    // Flush beats load; with neither asserted the register simply holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= flush_data_i;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            data_q  <= flush_data_i;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_pipe_ctrl.sv
// rtl/fetch_pipe_ctrl.sv - PC register, IF/ID register and hazard/redirect control FSM
module fetch_pipe_ctrl
    import fetch_pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PcWrite,
    input  logic             IF_IDWrite,
    input  logic             Stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      if_id_pc,
    output logic [31:0]      if_id_instr,
    output logic             if_id_valid,
    output logic             id_ex_bubble,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    logic [31:0]      pc_q, pc_d;
    fetch_state_e     state_q, state_d;
    logic             bubble_q, bubble_d;
    logic             ifid_load, ifid_flush;
    logic [CNT_W-1:0] stall_cnt_q, squash_cnt_q;
    logic [63:0]      ifid_data;
    logic             hold_both;

    // Mixed write enables are illegal; they fall back to the safe load-use hold.
    assign hold_both = (Stall && !PcWrite && !IF_IDWrite) || (PcWrite != IF_IDWrite);

    always_comb begin
        pc_d       = pc_q;
        state_d    = ST_RUN;
        bubble_d   = 1'b0;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        if (redirect_valid) begin
            pc_d       = redirect_pc;
            ifid_flush = 1'b1;
            bubble_d   = 1'b1;
            state_d    = ST_SQUASH;
        end else if (hold_both) begin
            bubble_d   = 1'b1;
            state_d    = ST_HOLD;
        end else if (Stall) begin
            pc_d       = pc_plus4(pc_q);
            ifid_flush = 1'b1;
            bubble_d   = 1'b1;
            state_d    = ST_SQUASH;
        end else begin
            if (PcWrite) pc_d = pc_plus4(pc_q);
            ifid_load  = IF_IDWrite;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            state_q      <= ST_BOOT;
            bubble_q     <= 1'b1;
            stall_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            pc_q     <= pc_d;
            state_q  <= state_d;
            bubble_q <= bubble_d;
            if (state_q == ST_HOLD && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (state_q == ST_SQUASH && squash_cnt_q != '1)
                squash_cnt_q <= squash_cnt_q + 1'b1;
        end
    end

    if_id_reg #(.W(64)) u_if_id (
        .clk          (clk),
        .rst          (rst),
        .load_i       (ifid_load),
        .flush_i      (ifid_flush),
        .flush_data_i ({NOP_INSTR, 32'h0000_0000}),
        .data_i       ({imem_rdata, pc_plus4(pc_q)}),
        .data_o       (ifid_data),
        .valid_o      (if_id_valid)
    );

    assign imem_addr    = pc_q;
    assign if_id_instr  = ifid_data[63:32];
    assign if_id_pc     = ifid_data[31:0];
    assign id_ex_bubble = bubble_q;
    assign state_o      = state_q;
    assign stall_cnt    = stall_cnt_q;
    assign squash_cnt   = squash_cnt_q;

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// tb/tb_fetch_pipe_ctrl.sv - table-driven bench for fetch_pipe_ctrl
module tb_fetch_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pcw, ifw, stall, rv;
    logic [31:0] rpc;
    logic [31:0] imem_addr, imem_rdata, if_id_pc, if_id_instr;
    logic        if_id_valid, id_ex_bubble;
    logic [1:0]  state;
    logic [15:0] stall_cnt, squash_cnt;

    logic        rst2 = 1'b1;
    logic        pcw2, ifw2, stall2;
    logic [31:0] imem_addr2, imem_rdata2, if_id_pc2, if_id_instr2;
    logic        if_id_valid2, id_ex_bubble2;
    logic [1:0]  state2;
    logic [1:0]  stall_cnt2, squash_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata  = imem_addr ^ 32'h1300_0000;
    assign imem_rdata2 = imem_addr2 ^ 32'h1300_0000;

    fetch_pipe_ctrl dut (
        .clk(clk), .rst(rst), .PcWrite(pcw), .IF_IDWrite(ifw), .Stall(stall),
        .redirect_valid(rv), .redirect_pc(rpc), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
        .if_id_valid(if_id_valid), .id_ex_bubble(id_ex_bubble), .state_o(state),
        .stall_cnt(stall_cnt), .squash_cnt(squash_cnt)
    );

    fetch_pipe_ctrl #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst2), .PcWrite(pcw2), .IF_IDWrite(ifw2), .Stall(stall2),
        .redirect_valid(1'b0), .redirect_pc(32'h0), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .if_id_pc(if_id_pc2), .if_id_instr(if_id_instr2),
        .if_id_valid(if_id_valid2), .id_ex_bubble(id_ex_bubble2), .state_o(state2),
        .stall_cnt(stall_cnt2), .squash_cnt(squash_cnt2)
    );

    typedef struct {
        logic        pcw, ifw, stall, rv;
        logic [31:0] rpc;
        logic [31:0] e_addr, e_instr, e_ifpc;
        logic        e_valid, e_bubble;
        logic [1:0]  e_state;
        logic [15:0] e_stall, e_squash;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " imem_addr"}, imem_addr, 32'h0);
        chk({tag, " if_id_instr"}, if_id_instr, 32'h0);
        chk({tag, " if_id_pc"}, if_id_pc, 32'h0);
        chk({tag, " if_id_valid"}, {31'h0, if_id_valid}, 32'h0);
        chk({tag, " id_ex_bubble"}, {31'h0, id_ex_bubble}, 32'h1);
        chk({tag, " state"}, {30'h0, state}, 32'h0);
        chk({tag, " stall_cnt"}, {16'h0, stall_cnt}, 32'h0);
        chk({tag, " squash_cnt"}, {16'h0, squash_cnt}, 32'h0);
    endtask

    initial begin
        //          pcw  ifw  stl  rv   rpc            addr           instr          ifpc           v    bub  st    stc    sqc
        vecs[0]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,        32'h4,         32'h1300_0000, 32'h4,         1'b1,1'b0,2'd1, 16'd0, 16'd0};
        vecs[1]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,        32'h8,         32'h1300_0004, 32'h8,         1'b1,1'b0,2'd1, 16'd0, 16'd0};
        vecs[2]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,        32'hC,         32'h1300_0008, 32'hC,         1'b1,1'b0,2'd1, 16'd0, 16'd0};
        vecs[3]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,        32'h10,        32'h1300_000C, 32'h10,        1'b1,1'b0,2'd1, 16'd0, 16'd0};
        vecs[4]  = '{1'b0,1'b0,1'b1,1'b0,32'h0,        32'h10,        32'h1300_000C, 32'h10,        1'b1,1'b1,2'd2, 16'd0, 16'd0};
        vecs[5]  = '{1'b0,1'b0,1'b1,1'b0,32'h0,        32'h10,        32'h1300_000C, 32'h10,        1'b1,1'b1,2'd2, 16'd1, 16'd0};
        vecs[6]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,        32'h14,        32'h1300_0010, 32'h14,        1'b1,1'b0,2'd1, 16'd2, 16'd0};
        vecs[7]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,        32'h18,        32'h1300_0014, 32'h18,        1'b1,1'b0,2'd1, 16'd2, 16'd0};
        vecs[8]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,        32'h1C,        32'h1300_0018, 32'h1C,        1'b1,1'b0,2'd1, 16'd2, 16'd0};
        vecs[9]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,        32'h20,        32'h1300_001C, 32'h20,        1'b1,1'b0,2'd1, 16'd2, 16'd0};
        vecs[10] = '{1'b1,1'b1,1'b1,1'b0,32'h0,        32'h24,        32'h0,         32'h0,         1'b0,1'b1,2'd3, 16'd2, 16'd0};
        vecs[11] = '{1'b1,1'b1,1'b0,1'b0,32'h0,        32'h28,        32'h1300_0024, 32'h28,        1'b1,1'b0,2'd1, 16'd2, 16'd1};
        vecs[12] = '{1'b0,1'b0,1'b1,1'b1,32'h80,       32'h80,        32'h0,         32'h0,         1'b0,1'b1,2'd3, 16'd2, 16'd1};
        vecs[13] = '{1'b1,1'b1,1'b0,1'b0,32'h0,        32'h84,        32'h1300_0080, 32'h84,        1'b1,1'b0,2'd1, 16'd2, 16'd2};
        vecs[14] = '{1'b1,1'b1,1'b0,1'b1,32'hFFFF_FFFC,32'hFFFF_FFFC, 32'h0,         32'h0,         1'b0,1'b1,2'd3, 16'd2, 16'd2};
        vecs[15] = '{1'b1,1'b1,1'b0,1'b0,32'h0,        32'h0,         32'hECFF_FFFC, 32'h0,         1'b1,1'b0,2'd1, 16'd2, 16'd3};
        vecs[16] = '{1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0,         32'hECFF_FFFC, 32'h0,         1'b1,1'b1,2'd2, 16'd2, 16'd3};
        vecs[17] = '{1'b0,1'b0,1'b1,1'b0,32'h0,        32'h0,         32'hECFF_FFFC, 32'h0,         1'b1,1'b1,2'd2, 16'd3, 16'd3};

        pcw = 1'b1; ifw = 1'b1; stall = 1'b0; rv = 1'b0; rpc = 32'h0;
        pcw2 = 1'b1; ifw2 = 1'b1; stall2 = 1'b0;

        step();
        check_reset("reset");
        rst = 1'b0;
        #1;
        chk("boot state", {30'h0, state}, 32'h0);

        for (int i = 0; i < 18; i++) begin
            pcw = vecs[i].pcw; ifw = vecs[i].ifw; stall = vecs[i].stall;
            rv = vecs[i].rv;   rpc = vecs[i].rpc;
            step();
            chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d if_id_instr", i), if_id_instr, vecs[i].e_instr);
            chk($sformatf("v%0d if_id_pc", i), if_id_pc, vecs[i].e_ifpc);
            chk($sformatf("v%0d if_id_valid", i), {31'h0, if_id_valid}, {31'h0, vecs[i].e_valid});
            chk($sformatf("v%0d id_ex_bubble", i), {31'h0, id_ex_bubble}, {31'h0, vecs[i].e_bubble});
            chk($sformatf("v%0d state", i), {30'h0, state}, {30'h0, vecs[i].e_state});
            chk($sformatf("v%0d stall_cnt", i), {16'h0, stall_cnt}, {16'h0, vecs[i].e_stall});
            chk($sformatf("v%0d squash_cnt", i), {16'h0, squash_cnt}, {16'h0, vecs[i].e_squash});
        end

        // Async reset in the middle of a HOLD: outputs must drop before any edge.
        rst = 1'b1;
        #2;
        check_reset("async rst");
        #1;
        rst = 1'b0;
        pcw = 1'b1; ifw = 1'b1; stall = 1'b0; rv = 1'b0;
        step();
        chk("resume imem_addr", imem_addr, 32'h4);
        chk("resume if_id_instr", if_id_instr, 32'h1300_0000);
        chk("resume if_id_valid", {31'h0, if_id_valid}, 32'h1);
        chk("resume state", {30'h0, state}, 32'h1);

        // Second instance: PC wrap out of reset and counter saturation with a 2-bit width.
        chk("dut2 reset addr", imem_addr2, 32'hFFFF_FFFC);
        rst2 = 1'b0;
        step();
        chk("dut2 wrap addr", imem_addr2, 32'h0);
        chk("dut2 wrap if_id_pc", if_id_pc2, 32'h0);
        chk("dut2 wrap if_id_instr", if_id_instr2, 32'hECFF_FFFC);
        pcw2 = 1'b0; ifw2 = 1'b0; stall2 = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("dut2 stall_cnt at 3", {30'h0, stall_cnt2}, 32'h3);
        step();
        step();
        chk("dut2 stall_cnt saturated", {30'h0, stall_cnt2}, 32'h3);
        chk("dut2 state hold", {30'h0, state2}, 32'h2);
        chk("dut2 addr held", imem_addr2, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
